// File: rtl/psr_if.sv
// Bundle of ALU-flag, window/mode request and PSR/WIM observation signals
// exchanged between the datapath and the processor state register unit.
interface psr_if;
    logic        icc_we;
    logic        n_in;
    logic        z_in;
    logic        v_in;
    logic        c_in;
    logic        save;
    logic        restore;
    logic        rett;
    logic        trap_take;
    logic        psr_we;
    logic [31:0] psr_in;
    logic        wim_we;
    logic [31:0] wim_in;
    logic [31:0] psr_out;
    logic [31:0] wim_out;
    logic [3:0]  icc;
    logic [4:0]  cwp;
    logic        cout;
    logic        win_overflow;
    logic        win_underflow;
    logic        illegal_cwp;
    logic        error_mode;

    // Datapath side: issues requests, observes state.
    modport master (
        output icc_we, n_in, z_in, v_in, c_in, save, restore, rett, trap_take,
               psr_we, psr_in, wim_we, wim_in,
        input  psr_out, wim_out, icc, cwp, cout, win_overflow, win_underflow,
               illegal_cwp, error_mode
    );

    // PSR unit side.
    modport slave (
        input  icc_we, n_in, z_in, v_in, c_in, save, restore, rett, trap_take,
               psr_we, psr_in, wim_we, wim_in,
        output psr_out, wim_out, icc, cwp, cout, win_overflow, win_underflow,
               illegal_cwp, error_mode
    );
endinterface

// File: rtl/psr_unit.sv
// Processor State Register and Window Invalid Mask unit. Captures ALU
// condition codes, arbitrates trap/WRPSR/RETT/SAVE/RESTORE updates of the
// window pointer and mode bits, and flags window overflow/underflow.
module psr_unit #(
    parameter int NWINDOWS = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    psr_if.slave bus
);
    localparam logic [4:0]  LAST_CWP = 5'(NWINDOWS - 1);
    localparam logic [5:0]  CWP_LIMIT = 6'(NWINDOWS);
    localparam logic [31:0] WIM_MASK = (NWINDOWS >= 32) ? 32'hFFFF_FFFF
                                     : ((32'd1 << NWINDOWS) - 32'd1);

    logic [3:0]  r_icc;
    logic [3:0]  r_pil;
    logic        r_s;
    logic        r_ps;
    logic        r_et;
    logic [4:0]  r_cwp;
    logic [31:0] r_wim;
    logic        r_err;
    logic        r_ovf;
    logic        r_unf;
    logic        r_ill;

    logic [4:0]  w_dec;
    logic [4:0]  w_inc;
    logic [3:0]  w_icc_arb;
    logic [3:0]  w_icc_nxt;
    logic [3:0]  w_pil_nxt;
    logic        w_s_nxt;
    logic        w_ps_nxt;
    logic        w_et_nxt;
    logic [4:0]  w_cwp_nxt;
    logic [31:0] w_wim_nxt;
    logic        w_err_nxt;
    logic        w_ovf_nxt;
    logic        w_unf_nxt;
    logic        w_ill_nxt;

    // Window neighbours of the current pointer, wrapping modulo NWINDOWS.
    assign w_dec = (r_cwp == 5'd0)     ? LAST_CWP : (r_cwp - 5'd1);
    assign w_inc = (r_cwp == LAST_CWP) ? 5'd0     : (r_cwp + 5'd1);

    // Next-state arbitration: trap > WRPSR > RETT > SAVE/RESTORE; icc and WIM writes ride alongside.
    always_comb begin
        w_icc_arb = r_icc;
        w_icc_nxt = r_icc;
        w_pil_nxt = r_pil;
        w_s_nxt   = r_s;
        w_ps_nxt  = r_ps;
        w_et_nxt  = r_et;
        w_cwp_nxt = r_cwp;
        w_wim_nxt = r_wim;
        w_err_nxt = r_err;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
        w_ill_nxt = 1'b0;
        if (r_err) begin
            // Error mode freezes everything until reset.
            w_err_nxt = 1'b1;
        end else begin
            if (bus.trap_take) begin
                if (r_et) begin
                    // Trap handler owns window spill, so no WIM check here.
                    w_ps_nxt  = r_s;
                    w_s_nxt   = 1'b1;
                    w_et_nxt  = 1'b0;
                    w_cwp_nxt = w_dec;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end else if (bus.psr_we) begin
                w_icc_arb = bus.psr_in[23:20];
                w_pil_nxt = bus.psr_in[11:8];
                w_s_nxt   = bus.psr_in[7];
                w_ps_nxt  = bus.psr_in[6];
                w_et_nxt  = bus.psr_in[5];
                if ({1'b0, bus.psr_in[4:0]} < CWP_LIMIT) begin
                    w_cwp_nxt = bus.psr_in[4:0];
                end else begin
                    w_ill_nxt = 1'b1;
                end
            end else if (bus.rett) begin
                if (r_wim[w_inc]) begin
                    w_unf_nxt = 1'b1;
                end else if (!r_et) begin
                    w_cwp_nxt = w_inc;
                    w_s_nxt   = r_ps;
                    w_et_nxt  = 1'b1;
                end else begin
                    // RETT with traps already enabled is a no-op.
                    w_cwp_nxt = r_cwp;
                end
            end else if (bus.save && !bus.restore) begin
                if (r_wim[w_dec]) begin
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_cwp_nxt = w_dec;
                end
            end else if (bus.restore && !bus.save) begin
                if (r_wim[w_inc]) begin
                    w_unf_nxt = 1'b1;
                end else begin
                    w_cwp_nxt = w_inc;
                end
            end else begin
                // No request, or conflicting SAVE+RESTORE: hold.
                w_cwp_nxt = r_cwp;
            end

            // ALU flag capture wins over the icc field of a same-cycle WRPSR.
            if (bus.icc_we) begin
                w_icc_nxt = {bus.n_in, bus.z_in, bus.v_in, bus.c_in};
            end else begin
                w_icc_nxt = w_icc_arb;
            end

            // WIM write lands after the edge; checks above used the old mask.
            if (bus.wim_we) begin
                w_wim_nxt = bus.wim_in & WIM_MASK;
            end else begin
                w_wim_nxt = r_wim;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_icc <= 4'd0;
            r_pil <= 4'd0;
            r_s   <= 1'b1;
            r_ps  <= 1'b0;
            r_et  <= 1'b0;
            r_cwp <= 5'd0;
            r_wim <= 32'd0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            r_ill <= 1'b0;
        end else begin
            r_icc <= w_icc_nxt;
            r_pil <= w_pil_nxt;
            r_s   <= w_s_nxt;
            r_ps  <= w_ps_nxt;
            r_et  <= w_et_nxt;
            r_cwp <= w_cwp_nxt;
            r_wim <= w_wim_nxt;
            r_err <= w_err_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
            r_ill <= w_ill_nxt;
        end
    end

    assign bus.psr_out       = {4'h0, 4'h0, r_icc, 6'b00_0000, 1'b0, 1'b0,
                                r_pil, r_s, r_ps, r_et, r_cwp};
    assign bus.wim_out       = r_wim;
    assign bus.icc           = r_icc;
    assign bus.cwp           = r_cwp;
    assign bus.cout          = r_icc[0];
    assign bus.win_overflow  = r_ovf;
    assign bus.win_underflow = r_unf;
    assign bus.illegal_cwp   = r_ill;
    assign bus.error_mode    = r_err;
endmodule

// File: tb/tb_psr_unit.sv
// Scoreboard bench for psr_unit: a driver applies directed and random
// stimulus and pushes the reference model's expected state; a monitor pops
// and compares one entry after every clock edge.
module tb_psr_unit;
    localparam int NW = 8;

    typedef struct packed {
        logic        rst;
        logic        icc_we;
        logic [3:0]  flags;
        logic        save;
        logic        restore;
        logic        rett;
        logic        trap;
        logic        psr_we;
        logic [31:0] psr_in;
        logic        wim_we;
        logic [31:0] wim_in;
    } stim_t;

    typedef struct packed {
        logic [31:0] psr;
        logic [31:0] wim;
        logic [3:0]  icc;
        logic [4:0]  cwp;
        logic        cout;
        logic        ovf;
        logic        unf;
        logic        ill;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    psr_if bus();

    psr_unit #(.NWINDOWS(NW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference state, kept as plain integers.
    int m_icc, m_pil, m_s, m_ps, m_et, m_cwp, m_wim, m_err, m_ovf, m_unf, m_ill;

    function automatic exp_t model_snapshot();
        exp_t e;
        e.psr  = 32'((m_icc << 20) | (m_pil << 8) | (m_s << 7) | (m_ps << 6) | (m_et << 5) | m_cwp);
        e.wim  = 32'(m_wim);
        e.icc  = 4'(m_icc);
        e.cwp  = 5'(m_cwp);
        e.cout = 1'(m_icc & 1);
        e.ovf  = 1'(m_ovf);
        e.unf  = 1'(m_unf);
        e.ill  = 1'(m_ill);
        e.err  = 1'(m_err);
        return e;
    endfunction

    task automatic model_step(input stim_t s);
        int dec, inc;
        dec = (m_cwp + NW - 1) % NW;
        inc = (m_cwp + 1) % NW;
        m_ovf = 0; m_unf = 0; m_ill = 0;
        if (s.rst) begin
            m_icc = 0; m_pil = 0; m_s = 1; m_ps = 0; m_et = 0; m_cwp = 0;
            m_wim = 0; m_err = 0;
        end else if (m_err == 0) begin
            if (s.trap) begin
                if (m_et == 1) begin
                    m_ps = m_s; m_s = 1; m_et = 0; m_cwp = dec;
                end else begin
                    m_err = 1;
                end
            end else if (s.psr_we) begin
                m_icc = int'(s.psr_in[23:20]);
                m_pil = int'(s.psr_in[11:8]);
                m_s   = int'(s.psr_in[7]);
                m_ps  = int'(s.psr_in[6]);
                m_et  = int'(s.psr_in[5]);
                if (int'(s.psr_in[4:0]) < NW) m_cwp = int'(s.psr_in[4:0]);
                else m_ill = 1;
            end else if (s.rett) begin
                if (((m_wim >> inc) & 1) == 1) m_unf = 1;
                else if (m_et == 0) begin
                    m_cwp = inc; m_s = m_ps; m_et = 1;
                end
            end else if (s.save && !s.restore) begin
                if (((m_wim >> dec) & 1) == 1) m_ovf = 1;
                else m_cwp = dec;
            end else if (s.restore && !s.save) begin
                if (((m_wim >> inc) & 1) == 1) m_unf = 1;
                else m_cwp = inc;
            end
            if (s.icc_we) m_icc = int'(s.flags);
            if (s.wim_we) m_wim = int'(s.wim_in) & ((1 << NW) - 1);
        end
    endtask

    task automatic apply(input stim_t s);
        @(negedge clk);
        rst           = s.rst;
        bus.icc_we    = s.icc_we;
        bus.n_in      = s.flags[3];
        bus.z_in      = s.flags[2];
        bus.v_in      = s.flags[1];
        bus.c_in      = s.flags[0];
        bus.save      = s.save;
        bus.restore   = s.restore;
        bus.rett      = s.rett;
        bus.trap_take = s.trap;
        bus.psr_we    = s.psr_we;
        bus.psr_in    = s.psr_in;
        bus.wim_we    = s.wim_we;
        bus.wim_in    = s.wim_in;
        model_step(s);
        q.push_back(model_snapshot());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Direct check against a constant from the worked examples, just after the edge.
    task automatic chk_now(input string name, input logic [31:0] act_sel, input logic [31:0] req);
        n_vec++;
        chk(name, act_sel, req);
    endtask

    // Monitor: after each edge, compare the DUT against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                n_vec++;
                chk("psr_out",  bus.psr_out, e.psr);
                chk("wim_out",  bus.wim_out, e.wim);
                chk("icc",      {28'd0, bus.icc}, {28'd0, e.icc});
                chk("cwp",      {27'd0, bus.cwp}, {27'd0, e.cwp});
                chk("cout",     {31'd0, bus.cout}, {31'd0, e.cout});
                chk("overflow", {31'd0, bus.win_overflow}, {31'd0, e.ovf});
                chk("underflow",{31'd0, bus.win_underflow}, {31'd0, e.unf});
                chk("illegal",  {31'd0, bus.illegal_cwp}, {31'd0, e.ill});
                chk("errmode",  {31'd0, bus.error_mode}, {31'd0, e.err});
            end
        end
    end

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        stim_t s;
        int r;
        int guard;

        s = '0; s.rst = 1'b1;
        apply(s); apply(s);
        settle(); chk_now("reset_psr", bus.psr_out, 32'h0000_0080);

        s = '0; s.icc_we = 1'b1; s.flags = 4'b1011;
        apply(s);
        settle(); chk_now("iccwe_psr", bus.psr_out, 32'h00B0_0080);
        chk_now("iccwe_cout", {31'd0, bus.cout}, 32'd1);

        s = '0; s.save = 1'b1; apply(s);
        settle(); chk_now("save_wrap_cwp", {27'd0, bus.cwp}, 32'd7);
        s = '0; s.restore = 1'b1; apply(s);
        settle(); chk_now("restore_wrap_cwp", {27'd0, bus.cwp}, 32'd0);

        s = '0; s.wim_we = 1'b1; s.wim_in = 32'h0000_0080; apply(s);
        s = '0; s.save = 1'b1; apply(s);
        settle(); chk_now("ovf_pulse", {31'd0, bus.win_overflow}, 32'd1);
        chk_now("ovf_cwp_held", {27'd0, bus.cwp}, 32'd0);
        s = '0; apply(s);
        settle(); chk_now("ovf_pulse_end", {31'd0, bus.win_overflow}, 32'd0);

        s = '0; s.wim_we = 1'b1; s.wim_in = 32'd0; apply(s);
        s = '0; s.psr_we = 1'b1; s.psr_in = 32'h0000_0F23; apply(s);
        settle(); chk_now("wrpsr_psr", bus.psr_out, 32'h0000_0F23);
        s = '0; s.psr_we = 1'b1; s.psr_in = 32'h0000_00AA; apply(s);
        settle(); chk_now("illegal_pulse", {31'd0, bus.illegal_cwp}, 32'd1);
        chk_now("illegal_psr", bus.psr_out, 32'h0000_00A3);

        s = '0; s.psr_we = 1'b1; s.psr_in = 32'h0000_0023; apply(s);
        s = '0; s.trap = 1'b1; apply(s);
        settle(); chk_now("trap_psr", bus.psr_out, 32'h0000_0082);
        s = '0; s.rett = 1'b1; apply(s);
        settle(); chk_now("rett_psr", bus.psr_out, 32'h0000_0023);
        s = '0; s.trap = 1'b1; apply(s);
        s = '0; s.wim_we = 1'b1; s.wim_in = 32'h0000_0008; apply(s);
        s = '0; s.rett = 1'b1; apply(s);
        settle(); chk_now("unf_pulse", {31'd0, bus.win_underflow}, 32'd1);
        chk_now("unf_psr_held", bus.psr_out, 32'h0000_0082);

        s = '0; s.trap = 1'b1; apply(s);
        settle(); chk_now("errmode_set", {31'd0, bus.error_mode}, 32'd1);
        s = '0; s.save = 1'b1; apply(s);
        settle(); chk_now("errmode_save_ign", {27'd0, bus.cwp}, 32'd2);
        s = '0; s.rst = 1'b1; apply(s);
        settle(); chk_now("errmode_clr_psr", bus.psr_out, 32'h0000_0080);

        s = '0; s.psr_we = 1'b1; s.psr_in = 32'h00F0_0020; s.icc_we = 1'b1; s.flags = 4'b0000;
        apply(s);
        settle(); chk_now("iccwe_over_psrwe", bus.psr_out, 32'h0000_0020);
        s = '0; s.save = 1'b1; s.restore = 1'b1; apply(s);
        settle(); chk_now("save_restore_cwp", {27'd0, bus.cwp}, 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            s = '0;
            s.rst    = ($urandom_range(0, 99) == 0);
            s.icc_we = ($urandom_range(0, 3) == 0);
            s.flags  = 4'($urandom);
            r = $urandom_range(0, 31);
            if (r == 0)       s.trap = 1'b1;
            else if (r < 4)   s.psr_we = 1'b1;
            else if (r < 8)   s.rett = 1'b1;
            else if (r < 14)  s.save = 1'b1;
            else if (r < 20)  s.restore = 1'b1;
            else if (r < 22)  begin s.save = 1'b1; s.restore = 1'b1; end
            if ($urandom_range(0, 7) == 0) s.rett = 1'b1;
            if ($urandom_range(0, 15) == 0) s.psr_we = 1'b1;
            s.psr_in = $urandom;
            if ($urandom_range(0, 3) != 0) s.psr_in[4:0] = 5'($urandom_range(0, NW - 1));
            s.wim_we = ($urandom_range(0, 7) == 0);
            s.wim_in = $urandom & $urandom & $urandom;
            apply(s);
        end

        s = '0; apply(s);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
